pattern_serializer: RTL and testbench

Parallel-in, serial-out transmitter that is the source end of the LED shift-register chain. It takes a WIDTH-bit pattern and presents one bit per tick on o_serial, MSB first. A receiving shift register clocked by the same tick ends up holding the pattern after WIDTH strobes. The block sits beside the 1 s tick path on the board top level and replaces the manual switch input as the serial data source.

---
 rtl/serializer_pkg.sv | 18 +
 rtl/serial_tick_gen.sv | 35 +++
 rtl/pattern_serializer.sv | 129 ++++++++++++
 tb/tb_pattern_serializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the LED serial chain: FSM state codes and default geometry,
// also used by the receiving shift register and the tick generator.
package serializer_pkg;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_TICK_DIV = 125000000;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Bit-period timer: o_tick pulses for one cycle every TICK_DIV enabled cycles.
// No latency beyond the count itself; i_clear restarts the period and wins over i_enable.
module serial_tick_gen
  import serializer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            CW   = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_enable & w_wrap;

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-in, serial-out source for the LED chain: one pattern bit per tick, MSB first.
// First strobe TICK_DIV cycles after load accept; loads while busy are dropped, abort wins over a strobe.
module pattern_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic             i_abort,
  output logic             o_serial,
  output logic             o_bit_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_done;

  logic w_accept;
  logic w_abort;
  logic w_enable;
  logic w_clear;
  logic w_tick;
  logic w_strobe;
  logic w_last;

  serial_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          w_next = ST_IDLE;
        end else if (w_tick && w_last) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_enable    = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = i_load;
      end
      ST_SHIFT: begin
        w_enable = 1'b1;
        w_abort  = i_abort;
        o_busy   = 1'b1;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // Abort masks the strobe of its own cycle, so a cancelled bit is never presented.
  assign w_clear     = w_accept | w_abort;
  assign w_strobe    = w_tick & ~w_abort;
  assign w_last      = (r_bit_cnt == LAST_BIT);
  assign o_bit_valid = w_strobe;

  // Zero fill means the register is empty after the final shift, which also idles o_serial low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shreg   <= i_pattern;
        r_bit_cnt <= '0;
      end else if (w_abort) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end else if (w_strobe) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        if (w_last) begin
          r_bit_cnt <= '0;
          r_done    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

  assign o_serial = r_shreg[WIDTH-1];
  assign o_done   = r_done;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: table-driven transfers plus randomized ones, checked
// cycle by cycle against a timeline model, with a sampled receiver for loopback.
module tb_pattern_serializer;

  localparam int W  = 10;
  localparam int TD = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         ld;
  logic         sel;
  logic         i_abort;
  logic [W-1:0] i_pattern;
  logic         ld0, ld1;
  logic         ser0, bv0, busy0, done0;
  logic         ser1, bv1, busy1, done1;
  logic         s_ser, s_bv, s_busy, s_done;

  int checks   = 0;
  int failures = 0;

  assign ld0    = ld & ~sel;
  assign ld1    = ld & sel;
  assign s_ser  = sel ? ser1  : ser0;
  assign s_bv   = sel ? bv1   : bv0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;

  pattern_serializer #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_load      (ld0),
    .i_pattern   (i_pattern),
    .i_abort     (i_abort),
    .o_serial    (ser0),
    .o_bit_valid (bv0),
    .o_busy      (busy0),
    .o_done      (done0)
  );

  pattern_serializer #(.WIDTH(W), .TICK_DIV(1)) dut_fast (
    .clk         (clk),
    .reset       (reset),
    .i_load      (ld1),
    .i_pattern   (i_pattern),
    .i_abort     (i_abort),
    .o_serial    (ser1),
    .o_bit_valid (bv1),
    .o_busy      (busy1),
    .o_done      (done1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy;
    logic bv;
    logic ser;
    logic done;
  } obs_t;

  typedef struct {
    logic [W-1:0] pat;
    int           abort_t;
    int           junk_t;
    bit           b2b;
    bit           use_fast;
    logic [W-1:0] exp_rx;
    int           exp_done;
  } vec_t;

  task automatic chk(input string name, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Expected outputs in cycle t after the load edge (t=1 is the first cycle after it).
  function automatic obs_t model(input logic [W-1:0] p, input int td, input int t, input int abort_t);
    obs_t o;
    int   n;
    o = '0;
    n = W * td;
    if (abort_t != 0 && t > abort_t) return o;
    if (t > n) begin
      o.done = 1'b1;
      return o;
    end
    o.busy = 1'b1;
    o.ser  = p[W - 1 - (t - 1) / td];
    o.bv   = ((t % td) == 0) && (t != abort_t);
    return o;
  endfunction

  task automatic check_all(input string tag, input int t, input obs_t e);
    chk({tag, "_busy"},  t, int'(s_busy), int'(e.busy));
    chk({tag, "_valid"}, t, int'(s_bv),   int'(e.bv));
    chk({tag, "_serial"}, t, int'(s_ser), int'(e.ser));
    chk({tag, "_done"},  t, int'(s_done), int'(e.done));
  endtask

  // Called mid-cycle; returns at the negedge of the done cycle (or the cycle after an abort).
  task automatic xfer(input logic [W-1:0] p, input int abort_t, input int junk_t,
                      output logic [W-1:0] rx, output int ndone);
    int   td;
    int   n;
    int   last_t;
    obs_t e;
    td     = sel ? 1 : TD;
    n      = W * td;
    last_t = (abort_t != 0) ? abort_t + 1 : n + 1;
    rx     = '0;
    ndone  = 0;
    i_abort   = 1'b0;
    ld        = 1'b1;
    i_pattern = p;
    @(posedge clk);
    #1;
    for (int t = 1; t <= last_t; t++) begin
      ld        = (t == junk_t);
      i_pattern = ld ? ~p : W'($urandom);
      i_abort   = (t == abort_t);
      @(negedge clk);
      e = model(p, td, t, abort_t);
      check_all("xfer", t, e);
      if (s_bv) rx = {rx[W-2:0], s_ser};
      if (s_done) ndone++;
      if (t < last_t) begin
        @(posedge clk);
        #1;
      end
    end
    ld      = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ld        = 1'b0;
      i_abort   = 1'($urandom_range(0, 1));
      i_pattern = W'($urandom);
      @(negedge clk);
      check_all("idle", i, '0);
    end
    i_abort = 1'b0;
  endtask

  // Start a transfer, then hit reset between edges; returns mid-cycle with reset released.
  task automatic reset_mid(input logic [W-1:0] p);
    ld        = 1'b1;
    i_pattern = p;
    @(posedge clk);
    #1;
    ld = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_busy", 0, int'(s_busy), 1);
    chk("pre_reset_serial", 0, int'(s_ser), int'(p[W-2]));
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, '0);
    reset = 1'b0;
  endtask

  vec_t         tbl[8];
  logic [W-1:0] rx;
  logic [W-1:0] p;
  logic [W-1:0] exp_rx;
  int           nd;
  int           n;
  int           ab;
  int           jk;
  int           k;
  int           gap;

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ld        = 1'b0;
    sel       = 1'b0;
    i_abort   = 1'b0;
    i_pattern = '0;

    tbl[0] = '{10'b1011001110, 0,  0,  1'b0, 1'b0, 10'b1011001110, 1};
    tbl[1] = '{10'h3FF,        0,  13, 1'b0, 1'b0, 10'h3FF,        1};
    tbl[2] = '{10'h2AA,        20, 0,  1'b0, 1'b0, 10'h00A,        0};
    tbl[3] = '{10'h001,        0,  0,  1'b1, 1'b0, 10'h001,        1};
    tbl[4] = '{10'h200,        0,  0,  1'b0, 1'b0, 10'h200,        1};
    tbl[5] = '{10'b1100110101, 0,  0,  1'b0, 1'b0, 10'b1100110101, 1};
    tbl[6] = '{10'b1100110101, 0,  0,  1'b0, 1'b1, 10'b1100110101, 1};
    tbl[7] = '{10'h3C5,        3,  2,  1'b0, 1'b1, 10'h003,        0};

    #1;
    check_all("reset_val", 0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    reset_mid(10'h3FF);
    idle(20);

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].use_fast;
      xfer(tbl[i].pat, tbl[i].abort_t, tbl[i].junk_t, rx, nd);
      chk("tbl_rx", i, int'(rx), int'(tbl[i].exp_rx));
      chk("tbl_ndone", i, nd, tbl[i].exp_done);
      if (!tbl[i].b2b) idle(2);
    end

    sel = 1'b0;
    reset_mid(10'h155);
    xfer(10'h155, 0, 0, rx, nd);
    chk("after_reset_rx", 0, int'(rx), int'(10'h155));
    idle(1);

    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom_range(0, 1));
      n   = W * (sel ? 1 : TD);
      p   = W'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      jk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (ab != 0) ? ab : n)) : 0;
      xfer(p, ab, jk, rx, nd);
      k      = (ab == 0) ? W : (ab - 1) / (sel ? 1 : TD);
      exp_rx = (k == 0) ? '0 : (p >> (W - k));
      chk("rand_rx", i, int'(rx), int'(exp_rx));
      chk("rand_ndone", i, nd, (ab == 0) ? 1 : 0);
      gap = int'($urandom_range(0, 3));
      if (gap != 0) idle(gap);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
